// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation selector codes, RV32I opcodes, decoded slot type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD       = 4'd0;
  localparam logic [3:0] ALU_SUB       = 4'd1;
  localparam logic [3:0] ALU_AND       = 4'd2;
  localparam logic [3:0] ALU_OR        = 4'd3;
  localparam logic [3:0] ALU_XOR       = 4'd4;
  localparam logic [3:0] ALU_SLL       = 4'd5;
  localparam logic [3:0] ALU_SLR       = 4'd6;
  localparam logic [3:0] ALU_SLT       = 4'd7;
  localparam logic [3:0] ALU_SLTU      = 4'd8;
  localparam logic [3:0] ALU_SRA       = 4'd9;
  localparam logic [3:0] ALU_OPERAND_B = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_sel;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [2:0]  branch_funct3;
    logic        illegal_instr;
    logic [31:0] pc_out;
  } decoded_op_t;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Handshake and data bundle around the decode stage.
// master: upstream fetch/regfile plus downstream execute; slave: the decode stage.
interface alu_decode_stage_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_operations_selector;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [2:0]  branch_funct3;
  logic        illegal_instr;
  logic [31:0] pc_out;

  modport master (
    output flush, in_valid, instruction, pc_in, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, alu_operations_selector,
           store_data, rd_addr, reg_write, mem_read, mem_write, branch,
           branch_funct3, illegal_instr, pc_out
  );

  modport slave (
    input  flush, in_valid, instruction, pc_in, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, operand_a, operand_b, alu_operations_selector,
           store_data, rd_addr, reg_write, mem_read, mem_write, branch,
           branch_funct3, illegal_instr, pc_out
  );
endinterface

// File: rtl/alu_decode_stage_imm_gen.sv
// Sign-extended RV32I immediates (I, S, U forms). Opcode bits are not needed here.
module imm_gen (
  input  logic [31:7] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_u
);

  // pure bit rearrangement with sign extension from instruction bit 31
  always_comb begin
    o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    o_imm_u = {i_instr[31:12], 12'h000};
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: builds ALU operands/selector and control flags into one
// registered slot with valid/ready on both sides and flush for redirects.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_decode_stage_if.slave  bus
);

  localparam decoded_op_t RESET_OP = '{pc_out: RESET_PC, default: '0};

  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_shamt;
  logic            w_illegal;
  logic            w_xfer;
  decoded_op_t     w_next;
  decoded_op_t     r_op;
  logic            r_valid;

  imm_gen u_imm_gen (
    .i_instr (bus.instruction[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_u (w_imm_u)
  );

  assign w_opcode = bus.instruction[6:0];
  assign w_f3     = bus.instruction[14:12];
  assign w_f7     = bus.instruction[31:25];
  assign w_shamt  = {27'd0, bus.instruction[24:20]};

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_xfer       = bus.in_valid && bus.in_ready;

  // decode the incoming instruction into the next slot contents
  always_comb begin
    w_next            = '0;
    w_next.pc_out     = bus.pc_in;
    w_next.store_data = bus.rs2_data;
    w_illegal         = 1'b0;
    unique case (w_opcode)
      OPC_OP: begin
        w_next.operand_a = bus.rs1_data;
        w_next.operand_b = bus.rs2_data;
        w_next.reg_write = 1'b1;
        if (w_f7 == F7_BASE) begin
          unique case (w_f3)
            3'b000: w_next.alu_sel = ALU_ADD;
            3'b001: w_next.alu_sel = ALU_SLL;
            3'b010: w_next.alu_sel = ALU_SLT;
            3'b011: w_next.alu_sel = ALU_SLTU;
            3'b100: w_next.alu_sel = ALU_XOR;
            3'b101: w_next.alu_sel = ALU_SLR;
            3'b110: w_next.alu_sel = ALU_OR;
            default: w_next.alu_sel = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_next.alu_sel = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_next.alu_sel = ALU_SRA;
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        w_next.operand_a = bus.rs1_data;
        w_next.operand_b = w_imm_i;
        w_next.reg_write = 1'b1;
        unique case (w_f3)
          3'b000: w_next.alu_sel = ALU_ADD;
          3'b010: w_next.alu_sel = ALU_SLT;
          3'b011: w_next.alu_sel = ALU_SLTU;
          3'b100: w_next.alu_sel = ALU_XOR;
          3'b110: w_next.alu_sel = ALU_OR;
          3'b111: w_next.alu_sel = ALU_AND;
          3'b001: begin
            w_next.operand_b = w_shamt;
            w_next.alu_sel   = ALU_SLL;
            w_illegal        = (w_f7 != F7_BASE);
          end
          default: begin
            w_next.operand_b = w_shamt;
            if (w_f7 == F7_BASE)     w_next.alu_sel = ALU_SLR;
            else if (w_f7 == F7_ALT) w_next.alu_sel = ALU_SRA;
            else                     w_illegal      = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        w_next.operand_b = w_imm_u;
        w_next.alu_sel   = ALU_OPERAND_B;
        w_next.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_next.operand_a = bus.pc_in;
        w_next.operand_b = w_imm_u;
        w_next.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        w_next.operand_a = bus.rs1_data;
        w_next.operand_b = w_imm_i;
        w_next.reg_write = 1'b1;
        w_next.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        w_next.operand_a = bus.rs1_data;
        w_next.operand_b = w_imm_s;
        w_next.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_next.operand_a     = bus.rs1_data;
        w_next.operand_b     = bus.rs2_data;
        w_next.branch        = 1'b1;
        w_next.branch_funct3 = w_f3;
        unique case (w_f3[2:1])
          2'b00:   w_next.alu_sel = ALU_SUB;
          2'b10:   w_next.alu_sel = ALU_SLT;
          2'b11:   w_next.alu_sel = ALU_SLTU;
          default: w_illegal      = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // link value pc+4; the jump target is resolved elsewhere
        w_next.operand_a = bus.pc_in;
        w_next.operand_b = 32'd4;
        w_next.reg_write = 1'b1;
        w_illegal        = (w_opcode == OPC_JALR) && (w_f3 != 3'b000);
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_next               = '0;
      w_next.pc_out        = bus.pc_in;
      w_next.store_data    = bus.rs2_data;
      w_next.illegal_instr = 1'b1;
    end
    w_next.rd_addr = w_next.reg_write ? bus.instruction[11:7] : 5'd0;
  end

  // pipeline slot: flush wins, then load on transfer, else drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_op    <= RESET_OP;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_op    <= w_next;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid               = r_valid;
  assign bus.operand_a               = r_op.operand_a;
  assign bus.operand_b               = r_op.operand_b;
  assign bus.alu_operations_selector = r_op.alu_sel;
  assign bus.store_data              = r_op.store_data;
  assign bus.rd_addr                 = r_op.rd_addr;
  assign bus.reg_write               = r_op.reg_write;
  assign bus.mem_read                = r_op.mem_read;
  assign bus.mem_write               = r_op.mem_write;
  assign bus.branch                  = r_op.branch;
  assign bus.branch_funct3           = r_op.branch_funct3;
  assign bus.illegal_instr           = r_op.illegal_instr;
  assign bus.pc_out                  = r_op.pc_out;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed vector bench for the decode stage plus handshake corner sequences.
module tb_alu_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_decode_stage_if u_if ();

  alu_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic [2:0]  bf3;
    logic        ill;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_slot(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".out_valid"}, 32'(u_if.out_valid), 32'd1);
    chk({t, ".a"}, u_if.operand_a, v.a);
    chk({t, ".b"}, u_if.operand_b, v.b);
    chk({t, ".sel"}, 32'(u_if.alu_operations_selector), 32'(v.sel));
    chk({t, ".rd"}, 32'(u_if.rd_addr), 32'(v.rd));
    chk({t, ".flags"},
        {27'd0, u_if.reg_write, u_if.mem_read, u_if.mem_write, u_if.branch, u_if.illegal_instr},
        {27'd0, v.rw, v.mr, v.mw, v.br, v.ill});
    chk({t, ".bf3"}, 32'(u_if.branch_funct3), 32'(v.bf3));
    chk({t, ".pc"}, u_if.pc_out, v.pc);
    if (v.mw) chk({t, ".store_data"}, u_if.store_data, v.rs2);
  endtask

  task automatic drive(input vec_t v);
    u_if.instruction = v.instr;
    u_if.pc_in       = v.pc;
    u_if.rs1_data    = v.rs1;
    u_if.rs2_data    = v.rs2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //           instr          pc            rs1           rs2           a             b             sel  rd  rw mr mw br bf3 ill
    vecs[0]  = '{32'h002081B3, 32'h0000_0040, 32'd5,        32'd7,        32'd5,        32'd7,        4'd0, 5'd3, 1, 0, 0, 0, 3'd0, 0};
    vecs[1]  = '{32'h40415093, 32'h0000_0044, 32'h8000_0000, 32'd0,       32'h8000_0000, 32'd4,       4'd9, 5'd1, 1, 0, 0, 0, 3'd0, 0};
    vecs[2]  = '{32'h00415093, 32'h0000_0048, 32'h8000_0000, 32'd0,       32'h8000_0000, 32'd4,       4'd6, 5'd1, 1, 0, 0, 0, 3'd0, 0};
    vecs[3]  = '{32'hFE415093, 32'h0000_004C, 32'h8000_0000, 32'd0,       32'd0,        32'd0,        4'd0, 5'd0, 0, 0, 0, 0, 3'd0, 1};
    vecs[4]  = '{32'h123452B7, 32'h0000_0050, 32'd9,        32'd9,        32'd0,        32'h1234_5000, 4'd15, 5'd5, 1, 0, 0, 0, 3'd0, 0};
    vecs[5]  = '{32'h0020E063, 32'h0000_0054, 32'd1,        32'd2,        32'd1,        32'd2,        4'd8, 5'd0, 0, 0, 0, 1, 3'd6, 0};
    vecs[6]  = '{32'h40628233, 32'h0000_0058, 32'd10,       32'd3,        32'd10,       32'd3,        4'd1, 5'd4, 1, 0, 0, 0, 3'd0, 0};
    vecs[7]  = '{32'h00208423, 32'h0000_005C, 32'h100,      32'hCAFE,     32'h100,      32'd8,        4'd0, 5'd0, 0, 0, 1, 0, 3'd0, 0};
    vecs[8]  = '{32'hFFC12383, 32'h0000_0060, 32'h1000,     32'd0,        32'h1000,     32'hFFFF_FFFC, 4'd0, 5'd7, 1, 1, 0, 0, 3'd0, 0};
    vecs[9]  = '{32'h00001097, 32'h0000_0100, 32'd0,        32'd0,        32'h100,      32'h1000,     4'd0, 5'd1, 1, 0, 0, 0, 3'd0, 0};
    vecs[10] = '{32'h000000EF, 32'h0000_0200, 32'd0,        32'd0,        32'h200,      32'd4,        4'd0, 5'd1, 1, 0, 0, 0, 3'd0, 0};
    vecs[11] = '{32'h00008067, 32'h0000_0300, 32'h44,       32'd0,        32'h300,      32'd4,        4'd0, 5'd0, 1, 0, 0, 0, 3'd0, 0};
    vecs[12] = '{32'h0020A063, 32'h0000_0304, 32'd1,        32'd2,        32'd0,        32'd0,        4'd0, 5'd0, 0, 0, 0, 0, 3'd0, 1};
    vecs[13] = '{32'h0000007F, 32'h0000_0308, 32'd1,        32'd2,        32'd0,        32'd0,        4'd0, 5'd0, 0, 0, 0, 0, 3'd0, 1};
    vecs[14] = '{32'h0020A1B3, 32'h0000_030C, 32'd1,        32'd2,        32'd1,        32'd2,        4'd7, 5'd3, 1, 0, 0, 0, 3'd0, 0};
    vecs[15] = '{32'h0F00F193, 32'h0000_0310, 32'hFF,       32'd0,        32'hFF,       32'hF0,       4'd2, 5'd3, 1, 0, 0, 0, 3'd0, 0};
    vecs[16] = '{32'h0020D063, 32'h0000_0314, 32'd3,        32'd4,        32'd3,        32'd4,        4'd7, 5'd0, 0, 0, 0, 1, 3'd5, 0};

    rst_n             = 1'b0;
    u_if.flush        = 1'b0;
    u_if.in_valid     = 1'b0;
    u_if.out_ready    = 1'b1;
    u_if.instruction  = '0;
    u_if.pc_in        = '0;
    u_if.rs1_data     = '0;
    u_if.rs2_data     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst.pc_out", u_if.pc_out, RST_PC);
    chk("rst.a", u_if.operand_a, 32'd0);
    chk("rst.flags", {27'd0, u_if.reg_write, u_if.mem_read, u_if.mem_write, u_if.branch,
        u_if.illegal_instr}, 32'd0);
    chk("rst.in_ready", 32'(u_if.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back vectors, one per cycle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      u_if.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_slot(i, vecs[i]);
    end

    // drain with nothing new
    @(negedge clk);
    u_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain.out_valid", 32'(u_if.out_valid), 32'd0);

    // backpressure: hold ADD for three cycles while SUB waits
    @(negedge clk);
    drive(vecs[0]);
    u_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[6]);
    u_if.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.in_ready", 32'(u_if.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("bp.out_valid", 32'(u_if.out_valid), 32'd1);
      chk("bp.a_frozen", u_if.operand_a, 32'd5);
      chk("bp.sel_frozen", 32'(u_if.alu_operations_selector), 32'd0);
      @(negedge clk);
    end
    u_if.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(u_if.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check_slot(100, vecs[6]);

    // flush with a held slot and an incoming instruction
    @(negedge clk);
    drive(vecs[0]);
    u_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[6]);
    u_if.flush = 1'b1;
    #1;
    chk("flush.in_ready", 32'(u_if.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("flush.out_valid", 32'(u_if.out_valid), 32'd0);
    @(negedge clk);
    u_if.flush    = 1'b0;
    u_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("flush.stays_empty", 32'(u_if.out_valid), 32'd0);

    // asynchronous reset in the middle of a held slot
    @(negedge clk);
    drive(vecs[8]);
    u_if.in_valid  = 1'b1;
    u_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("arst.loaded", 32'(u_if.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(u_if.out_valid), 32'd0);
    chk("arst.pc_out", u_if.pc_out, RST_PC);
    chk("arst.flags", {27'd0, u_if.reg_write, u_if.mem_read, u_if.mem_write, u_if.branch,
        u_if.illegal_instr}, 32'd0);
    chk("arst.b", u_if.operand_b, 32'd0);
    @(negedge clk);
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    rst_n          = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.no_replay", 32'(u_if.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
